stopwatch_seq_ctrl: RTL

Synchronous sequencer for the stopwatch counter datapath. It synchronises and debounces the three raw push-keys (start, pause, load) and runs the stopwatch mode FSM. It generates the count-enable tick from the system clock, plus one-cycle clear and load strobes for the downstream BCD counter chain. It sits between the board keys and the watch counter/preset logic, and replaces edge-clocked key handling with a single-clock design.

---
 rtl/stopwatch_seq_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_seq_ctrl.sv
// Stopwatch sequencer: key sync/debounce, mode FSM, count-tick prescaler and clear/load strobes.
// A press reaches the FSM two cycles after its debounced rise; every output is registered.

module stopwatch_seq_ctrl #(
   parameter int DIV     = 500000,
   parameter int DEB_CNT = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_start,
   input  logic       key_pause,
   input  logic       key_load,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       cnt_load,
   output logic [1:0] state
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      STOP  = 2'b11
   } mode_t;

   mode_t         mode;
   mode_t         mode_nxt;
   logic [2:0]    keys;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    deb;
   logic [2:0]    deb_d;
   logic [2:0]    press;
   logic [2:0]    sel;
   logic [DW-1:0] deb_cnt [3];
   logic [PW-1:0] pre;
   logic          accept;
   logic          pre_zero;
   logic          advance;
   logic          wrap;
   logic          clr_nxt;
   logic          load_nxt;

   // bit 0 start, bit 1 pause, bit 2 load
   assign keys = {key_load, key_pause, key_start};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         press <= '0;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= keys;
         sync2 <= sync1;
         deb_d <= deb;
         press <= deb & ~deb_d;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Only the highest-priority press is considered; the rest are dropped.
   always_comb begin
      sel      = 3'b000;
      mode_nxt = mode;
      accept   = 1'b0;
      pre_zero = 1'b0;
      clr_nxt  = 1'b0;
      load_nxt = 1'b0;
      if (press[0])      sel = 3'b001;
      else if (press[1]) sel = 3'b010;
      else if (press[2]) sel = 3'b100;
      case (mode)
         IDLE: begin
            if (sel[0]) begin
               mode_nxt = RUN;
               pre_zero = 1'b1;
               accept   = 1'b1;
            end else if (sel[2]) begin
               load_nxt = 1'b1;
               accept   = 1'b1;
            end
         end
         RUN: begin
            if (sel[0]) begin
               mode_nxt = STOP;
               accept   = 1'b1;
            end else if (sel[1]) begin
               mode_nxt = PAUSE;
               accept   = 1'b1;
            end
         end
         PAUSE: begin
            if (sel[1]) begin
               mode_nxt = RUN;
               accept   = 1'b1;
            end else if (sel[0]) begin
               mode_nxt = STOP;
               accept   = 1'b1;
            end
         end
         STOP: begin
            if (sel[0]) begin
               mode_nxt = IDLE;
               clr_nxt  = 1'b1;
               accept   = 1'b1;
            end else if (sel[2]) begin
               load_nxt = 1'b1;
               accept   = 1'b1;
            end
         end
         default: mode_nxt = IDLE;
      endcase
   end

   // Any accepted event while running freezes the prescaler, so leaving RUN never ticks.
   assign advance = (mode == RUN) && !accept;
   assign wrap    = advance && (pre == PRE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         mode     <= IDLE;
         pre      <= '0;
         cnt_en   <= 1'b0;
         cnt_clr  <= 1'b0;
         cnt_load <= 1'b0;
      end else begin
         mode     <= mode_nxt;
         cnt_en   <= wrap;
         cnt_clr  <= clr_nxt;
         cnt_load <= load_nxt;
         if (pre_zero)     pre <= '0;
         else if (advance) pre <= wrap ? '0 : pre + 1'b1;
      end
   end

   assign state = mode;

endmodule
